// File: rtl/bus_io_bridge.sv
// bus_io_bridge: responder end of the single-cycle CPU data bus.
//
// Decodes every CPU access and routes it either to the data RAM or to the on-board
// I/O block (7-segment display, LEDs, switches, buttons, optional timer). Reads are
// combinational so the CPU can consume them in the same cycle; writes commit on the
// rising edge of cpu_clk.
//
// Optional feature: define TIMER_EN to build the free-running timer (count at
// 0xFFFFF020, divisor at 0xFFFFF024). Without it those addresses behave as unmapped I/O.
//
// Parameters:
//   SCAN_DIV   clock cycles each display digit stays lit
//   DRAM_AW    DRAM word-address width
//
// Ports:
//   cpu_clk, cpu_rst        clock, asynchronous active-low reset
//   Bus_addr/wen/wdata      CPU access
//   Bus_rdata               combinational read data to the CPU
//   dram_addr/wen/wdata     DRAM request (word address = Bus_addr[DRAM_AW+1:2])
//   dram_rdata              DRAM asynchronous read data
//   sw, btn                 raw asynchronous switch / button pins
//   led                     LED drive, active-high
//   dig_en, dig_seg         display digit enables and segments {dp,g..a}, active-low

module bus_io_bridge #(
  parameter int unsigned SCAN_DIV = 20000,
  parameter int unsigned DRAM_AW  = 14
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        Bus_addr,
  input  logic               Bus_wen,
  input  logic [31:0]        Bus_wdata,
  output logic [31:0]        Bus_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw,
  input  logic [4:0]         btn,
  output logic [23:0]        led,
  output logic [7:0]         dig_en,
  output logic [7:0]         dig_seg
);

  localparam logic [11:0] OffDisp  = 12'h000;
  localparam logic [11:0] OffCount = 12'h020;
  localparam logic [11:0] OffDiv   = 12'h024;
  localparam logic [11:0] OffLed   = 12'h060;
  localparam logic [11:0] OffSw    = 12'h070;
  localparam logic [11:0] OffBtn   = 12'h078;

  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

  // ---------------------------------------------------------------------------
  // Address decode and write strobes
  // ---------------------------------------------------------------------------
  logic        io_sel;
  logic [11:0] io_off;
  logic        wr_disp;
  logic        wr_led;

  assign io_sel  = (Bus_addr[31:12] == 20'hFFFFF);
  assign io_off  = Bus_addr[11:0];
  assign wr_disp = io_sel & Bus_wen & (io_off == OffDisp);
  assign wr_led  = io_sel & Bus_wen & (io_off == OffLed);

  assign dram_addr  = Bus_addr[DRAM_AW+1:2];
  assign dram_wen   = Bus_wen & ~io_sel;
  assign dram_wdata = Bus_wdata;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [23:0]      led_q, led_d;
  logic [31:0]      disp_q, disp_d;
  logic [23:0]      sw_s1_q, sw_s2_q;
  logic [4:0]       btn_s1_q, btn_s2_q;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       dig_en_q, dig_en_d;
  logic [7:0]       dig_seg_q, dig_seg_d;

`ifdef TIMER_EN
  logic        wr_count;
  logic        wr_div;
  logic        tick;
  logic [31:0] count_q, count_d;
  logic [31:0] div_q, div_d;
  logic [31:0] presc_q, presc_d;

  assign wr_count = io_sel & Bus_wen & (io_off == OffCount);
  assign wr_div   = io_sel & Bus_wen & (io_off == OffDiv);
`endif

  // Hex glyph, active-low {dp,g,f,e,d,c,b,a}, decimal point off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    led_d  = led_q;
    disp_d = disp_q;
    if (wr_led)  led_d  = Bus_wdata[23:0];
    if (wr_disp) disp_d = Bus_wdata;
  end

  // Display scan: outputs are registered from the current index, so the first
  // digit appears one edge after reset release and the glyph tracks a data
  // write on the following edge.
  always_comb begin
    if (scan_q == ScanLast) begin
      scan_d = '0;
      idx_d  = idx_q + 3'd1;
    end else begin
      scan_d = scan_q + 1'b1;
      idx_d  = idx_q;
    end
    dig_en_d  = ~(8'd1 << idx_q);
    dig_seg_d = hex_glyph(disp_q[{idx_q, 2'b00} +: 4]);
  end

`ifdef TIMER_EN
  // Divisor 0 or 1 ticks every cycle; otherwise tick when the prescaler
  // reaches divisor-1. A count write overrides a coincident tick.
  always_comb begin
    tick    = (div_q <= 32'd1) || (presc_q == (div_q - 32'd1));
    presc_d = tick ? 32'd0 : (presc_q + 32'd1);
    count_d = tick ? (count_q + 32'd1) : count_q;
    div_d   = div_q;
    if (wr_div) begin
      div_d   = Bus_wdata;
      presc_d = 32'd0;
    end
    if (wr_count) count_d = Bus_wdata;
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  logic [31:0] io_rdata;

  always_comb begin
    case (io_off)
      OffDisp:  io_rdata = disp_q;
`ifdef TIMER_EN
      OffCount: io_rdata = count_q;
      OffDiv:   io_rdata = div_q;
`endif
      OffLed:   io_rdata = {8'h00, led_q};
      OffSw:    io_rdata = {8'h00, sw_s2_q};
      OffBtn:   io_rdata = {27'h0, btn_s2_q};
      default:  io_rdata = 32'h0;
    endcase
    Bus_rdata = io_sel ? io_rdata : dram_rdata;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      led_q     <= '0;
      disp_q    <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      scan_q    <= '0;
      idx_q     <= '0;
      dig_en_q  <= 8'hFF;
      dig_seg_q <= 8'hFF;
`ifdef TIMER_EN
      count_q   <= '0;
      div_q     <= '0;
      presc_q   <= '0;
`endif
    end else begin
      led_q     <= led_d;
      disp_q    <= disp_d;
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      btn_s1_q  <= btn;
      btn_s2_q  <= btn_s1_q;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      dig_en_q  <= dig_en_d;
      dig_seg_q <= dig_seg_d;
`ifdef TIMER_EN
      count_q   <= count_d;
      div_q     <= div_d;
      presc_q   <= presc_d;
`endif
    end
  end

  assign led     = led_q;
  assign dig_en  = dig_en_q;
  assign dig_seg = dig_seg_q;

endmodule

// File: tb/tb_bus_io_bridge.sv
// Testbench for bus_io_bridge (SCAN_DIV=4): directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_bus_io_bridge;

  localparam int unsigned ScanDiv = 4;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b0;
  logic [31:0] Bus_addr = '0;
  logic        Bus_wen = 1'b0;
  logic [31:0] Bus_wdata = '0;
  logic [31:0] Bus_rdata;
  logic [13:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw = '0;
  logic [4:0]  btn = '0;
  logic [23:0] led;
  logic [7:0]  dig_en;
  logic [7:0]  dig_seg;

  bus_io_bridge #(
    .SCAN_DIV (ScanDiv),
    .DRAM_AW  (14)
  ) dut (
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .Bus_addr   (Bus_addr),
    .Bus_wen    (Bus_wen),
    .Bus_wdata  (Bus_wdata),
    .Bus_rdata  (Bus_rdata),
    .dram_addr  (dram_addr),
    .dram_wen   (dram_wen),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .sw         (sw),
    .btn        (btn),
    .led        (led),
    .dig_en     (dig_en),
    .dig_seg    (dig_seg)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Simple DRAM behind the bridge.
  logic [31:0] mem [0:16383];
  initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
  always @(posedge cpu_clk) if (dram_wen) mem[dram_addr] <= dram_wdata;
  assign dram_rdata = mem[dram_addr];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
    Bus_addr  = a;
    Bus_wen   = w;
    Bus_wdata = d;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_dwen;
    logic [13:0] exp_daddr;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Random-phase model state.
  logic [23:0] m_led;
  logic [31:0] m_disp;
  logic [31:0] mdl_mem [int];
  logic [23:0] swh[$];
  logic [4:0]  btnh[$];
  logic [7:0]  exp_en, exp_seg;
  logic [11:0] unm[10];

  initial begin
    logic [7:0]  en_e;
    logic [31:0] a, d, e;
    logic        w;
    int          edges, sel;

    vecs[0]  = '{32'h0000_0040, 1'b1, 32'h1234_5678, 32'h0,         1'b1, 14'd16};
    vecs[1]  = '{32'h0000_0040, 1'b0, 32'h0,         32'h1234_5678, 1'b0, 14'd16};
    vecs[2]  = '{32'hFFFF_F060, 1'b1, 32'h0000_00A5, 32'h0,         1'b0, 14'h3C18};
    vecs[3]  = '{32'hFFFF_F060, 1'b0, 32'h0,         32'h0000_00A5, 1'b0, 14'h3C18};
    vecs[4]  = '{32'hFFFF_F060, 1'b1, 32'hFFFF_FFFF, 32'h0000_00A5, 1'b0, 14'h3C18};
    vecs[5]  = '{32'hFFFF_F060, 1'b0, 32'h0,         32'h00FF_FFFF, 1'b0, 14'h3C18};
    vecs[6]  = '{32'hFFFF_F100, 1'b1, 32'h0000_0005, 32'h0,         1'b0, 14'h3C40};
    vecs[7]  = '{32'hFFFF_F100, 1'b0, 32'h0,         32'h0,         1'b0, 14'h3C40};
    vecs[8]  = '{32'h0000_F100, 1'b0, 32'h0,         32'h0,         1'b0, 14'h3C40};
    vecs[9]  = '{32'hFFFF_F070, 1'b1, 32'hDEAD_BEEF, 32'h0,         1'b0, 14'h3C1C};
    vecs[10] = '{32'hFFFF_F070, 1'b0, 32'h0,         32'h0,         1'b0, 14'h3C1C};
    vecs[11] = '{32'h0000_F070, 1'b0, 32'h0,         32'h0,         1'b0, 14'h3C1C};

    unm = '{12'h004, 12'h010, 12'h040, 12'h064, 12'h074, 12'h07C, 12'h100, 12'hFFC,
`ifdef TIMER_EN
            12'h028, 12'h02C};
`else
            12'h020, 12'h024};
`endif

    // ---- reset state ----
    drive(32'hFFFF_F060, 1'b0, 32'h0);
    repeat (2) @(negedge cpu_clk);
    #1;
    chk("rst_led", led, 32'h0);
    chk("rst_dig_en", dig_en, 32'hFF);
    chk("rst_dig_seg", dig_seg, 32'hFF);
    chk("rst_led_read", Bus_rdata, 32'h0);

    // ---- display scan: write 0x3F on edge 1 ----
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    drive(32'hFFFF_F000, 1'b1, 32'h0000_003F);
    @(negedge cpu_clk);
    drive(32'hFFFF_F000, 1'b0, 32'h0);
    #1;
    chk("disp_e1_en", dig_en, 32'hFE);
    chk("disp_e1_seg_old", dig_seg, 32'hC0);
    chk("disp_read", Bus_rdata, 32'h3F);
    for (int k = 2; k <= 34; k++) begin
      @(negedge cpu_clk);
      #1;
      en_e = ~(8'd1 << (((k - 1) / ScanDiv) % 8));
      chk($sformatf("disp_e%0d_en", k), dig_en, en_e);
      chk($sformatf("disp_e%0d_seg", k), dig_seg,
          glyph(4'(32'h3F >> (4 * (((k - 1) / ScanDiv) % 8)))));
    end

    // ---- routing table ----
    foreach (vecs[i]) begin
      @(negedge cpu_clk);
      drive(vecs[i].addr, vecs[i].wen, vecs[i].wdata);
      #1;
      chk($sformatf("vec%0d_rdata", i), Bus_rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_dram_wen", i), dram_wen, vecs[i].exp_dwen);
      chk($sformatf("vec%0d_dram_addr", i), dram_addr, vecs[i].exp_daddr);
    end
    @(negedge cpu_clk);
    drive(32'hFFFF_F060, 1'b0, 32'h0);
    #1;
    chk("led_pins", led, 32'h00FF_FFFF);

    // ---- asynchronous reset in the middle of a cycle ----
    @(posedge cpu_clk);
    #2;
    cpu_rst = 1'b0;
    #1;
    chk("async_rst_led", led, 32'h0);
    chk("async_rst_dig_en", dig_en, 32'hFF);
    chk("async_rst_dig_seg", dig_seg, 32'hFF);
    chk("async_rst_read", Bus_rdata, 32'h0);
    @(negedge cpu_clk);
    cpu_rst = 1'b1;

    // ---- switch / button synchronizer latency ----
    @(negedge cpu_clk);
    sw = 24'hABCDEF;
    drive(32'hFFFF_F070, 1'b0, 32'h0);
    #1;
    chk("sw_e0", Bus_rdata, 32'h0);
    @(negedge cpu_clk); #1;
    chk("sw_e1", Bus_rdata, 32'h0);
    @(negedge cpu_clk); #1;
    chk("sw_e2", Bus_rdata, 32'h00AB_CDEF);
    btn = 5'h15;
    drive(32'hFFFF_F078, 1'b0, 32'h0);
    #1;
    chk("btn_e0", Bus_rdata, 32'h0);
    @(negedge cpu_clk); #1;
    chk("btn_e1", Bus_rdata, 32'h0);
    @(negedge cpu_clk); #1;
    chk("btn_e2", Bus_rdata, 32'h15);

    // ---- timer ----
`ifdef TIMER_EN
    @(negedge cpu_clk);
    drive(32'hFFFF_F024, 1'b1, 32'd3);
    @(negedge cpu_clk);
    drive(32'hFFFF_F020, 1'b1, 32'd0);
    begin
      // Expected count read after each edge following the count=0 write.
      logic [31:0] exp_cnt[12];
      exp_cnt = '{32'd0, 32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,
                  32'd0, 32'd0, 32'h100, 32'h100, 32'h100, 32'h101};
      for (int k = 0; k < 12; k++) begin
        @(negedge cpu_clk);
        drive(32'hFFFF_F020, 1'b0, 32'h0);
        #1;
        chk($sformatf("timer_e%0d", k + 1), Bus_rdata, exp_cnt[k]);
        if (k == 2) drive(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFF);
        if (k == 7) drive(32'hFFFF_F020, 1'b1, 32'h100);
      end
    end
    @(negedge cpu_clk);
    drive(32'hFFFF_F024, 1'b1, 32'd0);
    #1;
    chk("timer_div_read", Bus_rdata, 32'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge cpu_clk);
      drive(32'hFFFF_F020, 1'b0, 32'h0);
      #1;
      chk($sformatf("timer_div0_%0d", k), Bus_rdata, 32'h101 + 32'(k));
    end
    drive(32'hFFFF_F024, 1'b0, 32'h0);
    #1;
    chk("timer_div0_read", Bus_rdata, 32'd0);
`else
    @(negedge cpu_clk);
    drive(32'hFFFF_F020, 1'b1, 32'd5);
    #1;
    chk("notimer_dram_wen", dram_wen, 32'd0);
    @(negedge cpu_clk);
    drive(32'hFFFF_F020, 1'b0, 32'h0);
    #1;
    chk("notimer_count_read", Bus_rdata, 32'd0);
    drive(32'hFFFF_F024, 1'b1, 32'd7);
    @(negedge cpu_clk);
    drive(32'hFFFF_F024, 1'b0, 32'h0);
    #1;
    chk("notimer_div_read", Bus_rdata, 32'd0);
`endif

    // ---- randomized run against the model ----
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    drive(32'h0, 1'b0, 32'h0);
    @(negedge cpu_clk);
    cpu_rst = 1'b1;
    m_led = '0;
    m_disp = '0;
    swh = '{24'h0, 24'h0};
    btnh = '{5'h0, 5'h0};
    exp_en = 8'hFF;
    exp_seg = 8'hFF;
    edges = 0;
    for (int c = 0; c < 300; c++) begin
      if (c != 0) @(negedge cpu_clk);
      if ($urandom_range(0, 3) == 0) sw = 24'($urandom);
      if ($urandom_range(0, 3) == 0) btn = 5'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0, 1:    a = {16'($urandom_range(0, 16'hFFFE)), 16'($urandom_range(256, 319) * 4)};
        2:       a = 32'hFFFF_F000;
        3:       a = 32'hFFFF_F060;
        4:       a = 32'hFFFF_F070;
        5:       a = 32'hFFFF_F078;
        default: a = {20'hFFFFF, unm[$urandom_range(0, 9)]};
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      drive(a, w, d);
      #1;
      if (a[31:12] != 20'hFFFFF) e = mdl_mem.exists(int'(a[15:2])) ? mdl_mem[int'(a[15:2])] : 32'h0;
      else if (a[11:0] == 12'h000) e = m_disp;
      else if (a[11:0] == 12'h060) e = {8'h0, m_led};
      else if (a[11:0] == 12'h070) e = {8'h0, swh[swh.size() - 2]};
      else if (a[11:0] == 12'h078) e = {27'h0, btnh[btnh.size() - 2]};
      else e = 32'h0;
      chk($sformatf("rnd%0d_rdata", c), Bus_rdata, e);
      chk($sformatf("rnd%0d_dram_wen", c), dram_wen, 32'(w && a[31:12] != 20'hFFFFF));
      chk($sformatf("rnd%0d_dram_addr", c), dram_addr, 32'(a[15:2]));
      chk($sformatf("rnd%0d_led", c), led, m_led);
      chk($sformatf("rnd%0d_dig_en", c), dig_en, exp_en);
      chk($sformatf("rnd%0d_dig_seg", c), dig_seg, exp_seg);
      @(posedge cpu_clk);
      edges++;
      exp_en = ~(8'd1 << (((edges - 1) / ScanDiv) % 8));
      exp_seg = glyph(4'(m_disp >> (4 * (((edges - 1) / ScanDiv) % 8))));
      if (w) begin
        if (a[31:12] != 20'hFFFFF) mdl_mem[int'(a[15:2])] = d;
        else if (a[11:0] == 12'h000) m_disp = d;
        else if (a[11:0] == 12'h060) m_led = d[23:0];
      end
      swh.push_back(sw);
      btnh.push_back(btn);
      void'(swh.pop_front());
      void'(btnh.pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_io_bridge.md
# bus_io_bridge

Responder end of the CPU data bus. It decodes each CPU access and routes it to the data RAM or to one of the on-board peripherals: 7-segment display, LEDs, switches, buttons and a free-running timer. Reads return data in the same cycle, because the single-cycle CPU consumes read data combinationally. Writes commit on the clock edge. The block sits between the CPU core's `Bus_*` port and the DRAM/peripheral pins at SoC top level.

## Interface
Parameters:
- `SCAN_DIV`, default 20000: clock cycles each display digit stays lit.
- `DRAM_AW`, default 14: DRAM word-address width.

Ports:
- `cpu_clk` in 1: system clock. All state updates on the rising edge.
- `cpu_rst` in 1: asynchronous, active-low reset.
- `Bus_addr` in 32: CPU byte address.
- `Bus_wen` in 1: CPU write strobe.
- `Bus_wdata` in 32: CPU write data.
- `Bus_rdata` out 32: read data returned to the CPU, combinational.
- `dram_addr` out DRAM_AW: DRAM word address, equal to `Bus_addr[DRAM_AW+1:2]`.
- `dram_wen` out 1: DRAM write enable.
- `dram_wdata` out 32: equal to `Bus_wdata`.
- `dram_rdata` in 32: DRAM asynchronous read data.
- `sw` in 24: raw switch inputs, asynchronous.
- `btn` in 5: raw button inputs, asynchronous.
- `led` out 24: LED drive, active-high.
- `dig_en` out 8: digit enables, active-low.
- `dig_seg` out 8: segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation
Address decode:
- `Bus_addr[31:12]==20'hFFFFF` selects the I/O region. Everything else goes to DRAM.
- I/O registers, all word accesses:
  - 0xFFFFF000 display data, R/W
  - 0xFFFFF020 timer count, R/W
  - 0xFFFFF024 timer divisor, R/W
  - 0xFFFFF060 LED, R/W, low 24 bits
  - 0xFFFFF070 switches, RO, zero-extended
  - 0xFFFFF078 buttons, RO, zero-extended
- `dram_wen = Bus_wen & !io_sel`. DRAM is never written for an I/O address.
- Unmapped I/O addresses read 0. Writes to them, to switches and to buttons are ignored.

`Bus_rdata` mux:
- DRAM region: `dram_rdata`.
- I/O region: the selected register value.

Synchronizers:
- `sw` and `btn` each pass through a 2-flop synchronizer.
- Reads return the second-stage value.

Display:
- 32-bit data register holds 8 hex nibbles. Digit i shows `data[4i+3:4i]`.
- Scan counter counts 0..SCAN_DIV-1. At wrap, the digit index advances 7→0 cyclically.
- `dig_en` is one-hot-low for the current index.
- `dig_seg` is the hex glyph for that nibble, decimal point off, registered.

Timer:
- Prescaler counts 0..divisor-1. On reaching divisor-1 it resets to 0 and `count` increments.
- `count` wraps from 0xFFFFFFFF to 0.
- Divisor 0 or 1 means `count` increments every cycle.
- A write to divisor loads it and clears the prescaler.
- A write to `count` loads it. If a tick coincides with the write, the written value wins and the tick is lost.

## Timing
Reset values, applied asynchronously:
- `led`=0, display data=0, `count`=0, divisor=0, prescaler=0.
- Synchronizer flops 0, scan counter 0, digit index 0.
- `dig_en`=8'hFF, `dig_seg`=8'hFF.
- First digit is driven one cycle after reset release.

Reads:
- Zero latency: `Bus_rdata` is valid in the same cycle as `Bus_addr`.
- Switch and button changes are visible 2 edges after the pin changes.

Writes:
- A register written at edge N shows the new value on reads from cycle N+1 onward.
- `led` updates at edge N.
- The display glyph updates at the next scan-register edge.

Simultaneous events:
- A timer read in the same cycle as a tick returns the pre-tick value.
- A reset assertion in the middle of a scan or count forces all reset values immediately.

## Configuration
- `TIMER_EN` defined: timer count, divisor and prescaler are implemented as described.
- `TIMER_EN` undefined: no timer logic. 0xFFFFF020 and 0xFFFFF024 read 0 and writes are ignored, as for any unmapped I/O address.

## Test plan
- Reset check: hold `cpu_rst`=0 → `led`=0, `dig_en`=8'hFF, `dig_seg`=8'hFF. Release reset → `dig_en`=8'hFE after 1 edge.
- Routing: write 0x12345678 to 0x00000040 → `dram_wen`=1, `dram_addr`=16. Write 0xA5 to 0xFFFFF060 → `dram_wen`=0, `led`=0x0000A5. Read 0xFFFFF060 → 0xA5.
- Switches: set `sw`=0xABCDEF and read 0xFFFFF070 each cycle → old value for 2 edges, then 0x00ABCDEF. Read 0xFFFFF100 → 0.
- Display scan (SCAN_DIV=4): write 0x0000003F to 0xFFFFF000 → digit 0 shows 'F' (8'h8E), digit 1 shows '3' (8'hB0), `dig_en` steps FE→FD every 4 cycles, and 7F returns to FE.
- Timer (TIMER_EN): divisor=3, count=0 → `count`=1 after 3 cycles. Write `count`=0xFFFFFFFF → wraps to 0 after 3 more cycles. A write on a tick cycle loads the written value.
- Timer compiled out (TIMER_EN undefined): write 5 to 0xFFFFF020 → reading it returns 0 and `dram_wen` stays 0.
